// File: rtl/fmac_ipcs_frm_ctrl.sv
// fmac_ipcs_frm_ctrl
// Store-and-forward frame controller in front of the 512x64 IPCS data FIFO.
// A frame is admitted only if a maximum-size frame still fits in the data
// FIFO. Otherwise the whole frame is dropped and counted. Each admitted
// frame's length and error bit go into a small length queue. The read side
// only starts a frame once its length entry exists, so only complete frames
// reach the checksum stage.
//
// Ports
//   clk, reset_        : single clock, asynchronous active-low reset
//   in_valid/sop/eop/data : upstream words, no backpressure
//   fifo_wrreq/data    : data FIFO write port (fifo_wrfull, fifo_usedw back)
//   fifo_rdreq/q       : data FIFO read port, q valid one cycle after rdreq
//   fifo_rdempty       : data FIFO empty
//   out_valid/sop/eop/err/data, out_ready : downstream stream
//   frm_pend           : complete frames waiting in the length queue
//   drop_cnt           : saturating dropped-frame counter
//   dbg_state          : {write FSM state, read FSM state}
//
// Handshake: a downstream word transfers on a rising edge where
// out_valid && out_ready. While out_valid && !out_ready the out_* outputs
// hold. out_valid never depends on out_ready.
module fmac_ipcs_frm_ctrl #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 512,
    parameter int PTR       = 9,
    parameter int MAX_WORDS = 192,
    parameter int LQ_DEPTH  = 16,
    parameter int LQ_PTR    = 4
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [WIDTH-1:0]  in_data,
    output logic              fifo_wrreq,
    output logic [WIDTH-1:0]  fifo_data,
    input  logic              fifo_wrfull,
    input  logic [PTR:0]      fifo_usedw,
    output logic              fifo_rdreq,
    input  logic [WIDTH-1:0]  fifo_q,
    input  logic              fifo_rdempty,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_err,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic [LQ_PTR:0]   frm_pend,
    output logic [15:0]       drop_cnt,
    output logic [2:0]        dbg_state
);

    localparam logic [PTR+1:0]  DEPTH_W = (PTR+2)'(DEPTH);
    localparam logic [PTR+1:0]  ADMIT_W = (PTR+2)'(MAX_WORDS + 1);
    localparam logic [PTR:0]    MAX_W   = (PTR+1)'(MAX_WORDS);
    localparam logic [PTR:0]    ONE_W   = (PTR+1)'(1);
    localparam logic [LQ_PTR:0] LQ_FULL = (LQ_PTR+1)'(LQ_DEPTH);
    localparam logic [LQ_PTR-1:0] LQ_ONE = (LQ_PTR)'(1);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_PASS = 2'd1, W_DROP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_XFER = 1'b1} r_state_t;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    w_state_t        w_state, w_next;
    logic [PTR:0]    wcnt;
    logic            trunc;
    logic [PTR+1:0]  free_words;
    logic            admit;
    logic            accept;
    logic            lq_push;
    logic            push_err;
    logic [PTR:0]    push_len;
    logic            drop_inc;
    logic            cnt_start;
    logic            cnt_step;
    logic            err_now;

    // Length queue
    logic [PTR+1:0]    lq_mem [LQ_DEPTH];
    logic [LQ_PTR-1:0] lq_wp, lq_rp;
    logic [LQ_PTR:0]   lq_count;
    logic              lq_full;
    logic              lq_pop;
    logic              push_ok;
    logic [PTR+1:0]    lq_head;

    assign free_words = DEPTH_W - {1'b0, fifo_usedw};
    assign lq_full    = (lq_count == LQ_FULL);
    assign admit      = (free_words >= ADMIT_W) && !lq_full;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (in_valid && in_sop && !in_eop) w_next = admit ? W_PASS : W_DROP;
            W_PASS: if (in_valid) begin
                if (in_sop)      w_next = in_eop ? W_IDLE : W_DROP;
                else if (in_eop) w_next = W_IDLE;
            end
            W_DROP: if (in_valid && in_eop) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write-side actions. A word that would hit a full FIFO is discarded
    // and marks the frame bad instead of being written.
    always_comb begin
        accept    = 1'b0;
        lq_push   = 1'b0;
        push_err  = 1'b0;
        push_len  = '0;
        drop_inc  = 1'b0;
        cnt_start = 1'b0;
        cnt_step  = 1'b0;
        err_now   = 1'b0;
        case (w_state)
            W_IDLE: if (in_valid && in_sop) begin
                if (admit) begin
                    accept    = !fifo_wrfull;
                    cnt_start = 1'b1;
                    if (in_eop) begin
                        lq_push  = 1'b1;
                        push_len = ONE_W;
                        push_err = fifo_wrfull;
                    end
                end else begin
                    drop_inc = 1'b1;
                end
            end
            W_PASS: if (in_valid) begin
                if (in_sop) begin
                    // Missing eop: close the current frame as bad and
                    // drop the frame that just started.
                    lq_push  = 1'b1;
                    push_err = 1'b1;
                    push_len = wcnt;
                    drop_inc = 1'b1;
                end else begin
                    cnt_step = 1'b1;
                    accept   = (wcnt < MAX_W) && !fifo_wrfull;
                    err_now  = !accept;
                    if (in_eop) begin
                        lq_push  = 1'b1;
                        push_err = trunc || err_now;
                        push_len = wcnt + {{PTR{1'b0}}, accept};
                    end
                end
            end
            default: ;
        endcase
    end

    assign fifo_wrreq = accept;
    assign fifo_data  = accept ? in_data : '0;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wcnt     <= '0;
            trunc    <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (cnt_start) begin
                wcnt  <= {{PTR{1'b0}}, accept};
                trunc <= !accept;
            end else if (cnt_step) begin
                if (accept) wcnt <= wcnt + ONE_W;
                trunc <= in_eop ? 1'b0 : (trunc || err_now);
            end
            if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Length queue: {err, len}
    // ------------------------------------------------------------------
    assign push_ok = lq_push && (!lq_full || lq_pop);
    assign lq_head = lq_mem[lq_rp];
    assign frm_pend = lq_count;

    always_ff @(posedge clk) begin
        if (push_ok) lq_mem[lq_wp] <= {push_err, push_len};
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            lq_wp    <= '0;
            lq_rp    <= '0;
            lq_count <= '0;
        end else begin
            if (push_ok) lq_wp <= lq_wp + LQ_ONE;
            if (lq_pop)  lq_rp <= lq_rp + LQ_ONE;
            case ({push_ok, lq_pop})
                2'b10:   lq_count <= lq_count + (LQ_PTR+1)'(1);
                2'b01:   lq_count <= lq_count - (LQ_PTR+1)'(1);
                default: lq_count <= lq_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    r_state_t     r_state, r_next;
    logic [PTR:0] rem;
    logic         rerr;
    logic         first;
    logic         inflight;
    logic         if_sop, if_eop, if_err;

    logic [WIDTH-1:0] sk_data [2];
    logic [1:0]       sk_sop, sk_eop, sk_err;
    logic             sk_rd, sk_wr;
    logic [1:0]       sk_cnt;
    logic             pop_out;
    logic [2:0]       occ_after;
    logic             room;

    assign out_valid = (sk_cnt != 2'd0);
    assign out_data  = sk_data[sk_rd];
    assign out_sop   = sk_sop[sk_rd];
    assign out_eop   = sk_eop[sk_rd];
    assign out_err   = sk_err[sk_rd];
    assign pop_out   = out_valid && out_ready;

    // Occupancy counts the word leaving this cycle as gone, so a steady
    // out_ready=1 sustains one read per cycle with a two-entry skid.
    assign occ_after = {1'b0, sk_cnt} + {2'b0, inflight} - {2'b0, pop_out};
    assign room      = (occ_after < 3'd2);

    // The next frame's entry is taken when the current frame has no reads
    // left, or is issuing its last read now, so frames follow back to back.
    assign lq_pop = (lq_count != '0) && ((rem == '0) || ((rem == ONE_W) && fifo_rdreq));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (lq_pop) r_next = R_XFER;
            R_XFER: if (!lq_pop && (rem == '0) && !inflight) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        fifo_rdreq = (r_state == R_XFER) && (rem != '0) && room && !fifo_rdempty;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rem      <= '0;
            rerr     <= 1'b0;
            first    <= 1'b0;
            inflight <= 1'b0;
            if_sop   <= 1'b0;
            if_eop   <= 1'b0;
            if_err   <= 1'b0;
        end else begin
            if (lq_pop) begin
                rem   <= lq_head[PTR:0];
                rerr  <= lq_head[PTR+1];
                first <= 1'b1;
            end else if (fifo_rdreq) begin
                rem   <= rem - ONE_W;
                first <= 1'b0;
            end
            inflight <= fifo_rdreq;
            // Tags are fixed at read time so they survive a frame switch.
            if (fifo_rdreq) begin
                if_sop <= first;
                if_eop <= (rem == ONE_W);
                if_err <= rerr && (rem == ONE_W);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sk_data[0] <= '0;
            sk_data[1] <= '0;
            sk_sop     <= '0;
            sk_eop     <= '0;
            sk_err     <= '0;
            sk_rd      <= 1'b0;
            sk_wr      <= 1'b0;
            sk_cnt     <= '0;
        end else begin
            if (inflight) begin
                sk_data[sk_wr] <= fifo_q;
                sk_sop[sk_wr]  <= if_sop;
                sk_eop[sk_wr]  <= if_eop;
                sk_err[sk_wr]  <= if_err;
                sk_wr          <= ~sk_wr;
            end
            if (pop_out) sk_rd <= ~sk_rd;
            sk_cnt <= sk_cnt + {1'b0, inflight} - {1'b0, pop_out};
        end
    end

    assign dbg_state = {w_state, r_state};

endmodule
